// File: rtl/mult_arbiter_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
// The FSM encoding and the tie-break rule live here so every file agrees on them.
package mult_arbiter_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_TO_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // A lone request wins outright; a tie goes to the requester not served last.
  function automatic logic pick_owner(input logic [1:0] valid, input logic last);
    return (valid == 2'b11) ? ~last : valid[1];
  endfunction

endpackage

// File: rtl/mult_arb_timer.sv
// Watchdog counter for the ISSUE phase: counts while enabled, flags the
// final cycle of the allowed window and reports the first counted cycle.
module mult_arb_timer
  import mult_arbiter_pkg::*;
#(
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired,
  output logic count_zero
);

  localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

  logic [CW-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every register updates from
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CW'(1);
  end

  assign expired    = (count == CW'(TO_CYCLES - 1));
  assign count_zero = (count == '0);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one multiplicador between two requesters,
// sequences its valid/done/ack handshake and returns the product per owner.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  output logic [1:0]         req_grant,
  output logic [1:0]         rsp_valid,
  output logic [2*WIDTH-1:0] rsp_producto,
  input  logic [1:0]         rsp_ack,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_valid_data,
  output logic               mul_ack,
  input  logic [2*WIDTH-1:0] mul_producto,
  input  logic               mul_done,
  output logic               busy,
  output logic               timeout_err
);

  state_t state, state_nxt;
  logic   owner, last;
  logic   expired, count_zero, timer_clear, timer_en;
  logic   capture_req, capture_rsp, rsp_done;
  logic   pick;

  assign pick = pick_owner(req_valid, last);
  assign busy = (state != IDLE);

  mult_arb_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (timer_clear),
    .enable     (timer_en),
    .expired    (expired),
    .count_zero (count_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    req_grant      = '0;
    rsp_valid      = '0;
    mul_valid_data = 1'b0;
    mul_ack        = 1'b0;
    timer_clear    = 1'b1;
    timer_en       = 1'b0;
    capture_req    = 1'b0;
    capture_rsp    = 1'b0;
    rsp_done       = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          capture_req = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        mul_valid_data   = 1'b1;
        timer_clear      = 1'b0;
        timer_en         = 1'b1;
        req_grant[owner] = count_zero;
        if (mul_done || expired) begin
          capture_rsp = 1'b1;
          state_nxt   = RELEASE;
        end
      end
      RELEASE: begin
        mul_ack = 1'b1;
        if (!mul_done) state_nxt = RESPOND;
      end
      RESPOND: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ack[owner]) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the operand/product registers are reset (not left uninitialised)
  // because they drive ports that must read zero while reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner        <= 1'b0;
      last         <= 1'b1;
      mul_a        <= '0;
      mul_b        <= '0;
      rsp_producto <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (capture_req) begin
        owner <= pick;
        mul_a <= pick ? req_a1 : req_a0;
        mul_b <= pick ? req_b1 : req_b0;
      end
      // A completed multiply wins over a watchdog expiry in the same cycle.
      if (capture_rsp) begin
        rsp_producto <= mul_done ? mul_producto : '0;
        if (!mul_done) timeout_err <= 1'b1;
      end
      if (rsp_done) last <= owner;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: behavioural multiplier stub, per-port
// requester drivers and a response scoreboard fed as requests are queued.
module tb_mult_arbiter;

  localparam int W   = 32;
  localparam int TO  = 16;
  localparam int LAT = 3;

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct packed { logic id; logic [2*W-1:0] p; } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid, req_grant, rsp_valid, rsp_ack;
  logic [W-1:0]   req_a0, req_b0, req_a1, req_b1, mul_a, mul_b;
  logic [2*W-1:0] rsp_producto, mul_producto;
  logic           mul_valid_data, mul_ack, mul_done, busy, timeout_err;

  int   checks = 0;
  int   errors = 0;
  op_t  pend0[$];
  op_t  pend1[$];
  exp_t sb[$];
  bit   grant_log[$];
  int   ack_count[2];
  int   ack_delay = 0;
  bit   stall = 1'b0;

  mult_arbiter #(.WIDTH(W), .TO_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_a0         (req_a0),
    .req_b0         (req_b0),
    .req_a1         (req_a1),
    .req_b1         (req_b1),
    .req_grant      (req_grant),
    .rsp_valid      (rsp_valid),
    .rsp_producto   (rsp_producto),
    .rsp_ack        (rsp_ack),
    .mul_a          (mul_a),
    .mul_b          (mul_b),
    .mul_valid_data (mul_valid_data),
    .mul_ack        (mul_ack),
    .mul_producto   (mul_producto),
    .mul_done       (mul_done),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Multiplier stub: LAT cycles after valid_data, raise Done_Flag and hold it until ack.
  logic [2*W-1:0] m_prod;
  int             m_cnt;
  bit             m_busy;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_done <= 1'b0; mul_producto <= '0; m_busy <= 1'b0; m_cnt <= 0; m_prod <= '0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        mul_done <= 1'b1; mul_producto <= m_prod; m_busy <= 1'b0;
      end else m_cnt <= m_cnt - 1;
    end else if (mul_done) begin
      if (mul_ack) mul_done <= 1'b0;
    end else if (mul_valid_data && !stall) begin
      m_busy <= 1'b1; m_cnt <= LAT; m_prod <= 64'(mul_a) * 64'(mul_b);
    end
  end

  // Requester drivers: hold the front operand pair until its grant is seen.
  initial begin
    req_valid = '0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    forever begin
      @(negedge clk);
      if (req_grant[0] === 1'b1) begin
        grant_log.push_back(1'b0);
        if (pend0.size() > 0) void'(pend0.pop_front());
      end
      if (req_grant[1] === 1'b1) begin
        grant_log.push_back(1'b1);
        if (pend1.size() > 0) void'(pend1.pop_front());
      end
      if (pend0.size() > 0) begin
        req_valid[0] = 1'b1; req_a0 = pend0[0].a; req_b0 = pend0[0].b;
      end else req_valid[0] = 1'b0;
      if (pend1.size() > 0) begin
        req_valid[1] = 1'b1; req_a1 = pend1[0].a; req_b1 = pend1[0].b;
      end else req_valid[1] = 1'b0;
    end
  end

  // Response consumer: compare against the scoreboard, hold for ack_delay, then ack.
  bit             c_id;
  logic [1:0]     c_v;
  logic [2*W-1:0] c_p;
  exp_t           c_e;
  initial begin
    rsp_ack = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && rsp_valid !== 2'b00) begin
        c_id = rsp_valid[1];
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b producto=%0d with empty scoreboard", rsp_valid, rsp_producto);
        end else begin
          c_e = sb.pop_front();
          if (rsp_valid !== (2'b01 << c_e.id) || rsp_producto !== c_e.p) begin
            errors++;
            $display("FAIL rsp_data: got valid=%b producto=%0d, want valid=%b producto=%0d",
                     rsp_valid, rsp_producto, 2'b01 << c_e.id, c_e.p);
          end
        end
        c_v = rsp_valid;
        c_p = rsp_producto;
        for (int k = 0; k < ack_delay; k++) begin
          rsp_ack = '0;
          rsp_ack[!c_id] = 1'b1;
          @(negedge clk);
          checks++;
          if (rsp_valid !== c_v || rsp_producto !== c_p) begin
            errors++;
            $display("FAIL rsp_hold: cycle %0d got valid=%b producto=%0d, want valid=%b producto=%0d",
                     k, rsp_valid, rsp_producto, c_v, c_p);
          end
        end
        rsp_ack = '0;
        rsp_ack[c_id] = 1'b1;
        ack_count[c_id]++;
        @(negedge clk);
        rsp_ack = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench did not complete, checks=%0d", checks);
    $fatal(1, "time limit reached");
  end

  task automatic add_req(input bit i, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_zero);
    op_t  o;
    exp_t e;
    o.a = a; o.b = b;
    e.id = i;
    e.p  = expect_zero ? '0 : 64'(a) * 64'(b);
    sb.push_back(e);
    if (i) pend1.push_back(o); else pend0.push_back(o);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pend0.delete(); pend1.delete(); sb.delete(); grant_log.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    @(negedge clk);
    while (req_grant[i] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (req_grant[i] !== 1'b1) begin
      errors++;
      $display("FAIL grant_wait: req_grant[%0d] not seen within 100 cycles, req_grant=%b", i, req_grant);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 400 && !(sb.size() == 0 && pend0.size() == 0 && pend1.size() == 0 && busy === 1'b0)) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL idle_wait: busy=%b scoreboard=%0d pending=%0d/%0d after 400 cycles",
               busy, sb.size(), pend0.size(), pend1.size());
    end
  endtask

  task automatic check_grants(input string name, input int n, input logic [3:0] order);
    checks++;
    if (grant_log.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d grants, want %0d", name, grant_log.size(), n);
    end else
      for (int k = 0; k < n; k++)
        if (grant_log[k] !== order[k]) begin
          errors++;
          $display("FAIL %s_order: grant %0d went to %0d, want %0d", name, k, grant_log[k], order[k]);
        end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_grant, rsp_valid, rsp_producto, mul_a, mul_b, mul_valid_data, mul_ack, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b rsp_valid=%b prod=%0d a=%0d b=%0d vd=%b ack=%b busy=%b to=%b, want all 0",
               req_grant, rsp_valid, rsp_producto, mul_a, mul_b, mul_valid_data, mul_ack, busy, timeout_err);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_grant !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: busy=%b grant=%b, want 0 with no requests", busy, req_grant);
    end
  endtask

  task automatic test_single();
    int n = 0;
    int bad = 0;
    grant_log.delete();
    add_req(1'b0, 32'd32, 32'd3, 1'b0);
    wait_grant(0);
    while (mul_done !== 1'b1 && n < 50) begin
      if (mul_valid_data !== 1'b1 || mul_a !== 32'd32 || mul_b !== 32'd3) bad++;
      @(negedge clk); n++;
    end
    checks++;
    if (bad != 0 || mul_done !== 1'b1 || mul_valid_data !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: %0d bad ISSUE cycles, done=%b valid_data=%b, want 0 bad and both 1", bad, mul_done, mul_valid_data);
    end
    @(negedge clk);
    checks++;
    if (mul_valid_data !== 1'b0 || mul_ack !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_release: valid_data=%b ack=%b busy=%b, want 0 1 1", mul_valid_data, mul_ack, busy);
    end
    wait_idle();
    check_grants("single_grant", 1, 4'b0000);
    checks++;
    if (busy !== 1'b0 || rsp_producto !== 64'd96) begin
      errors++;
      $display("FAIL single_after: busy=%b producto=%0d, want 0 and 96 held", busy, rsp_producto);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    add_req(1'b0, 32'd7, 32'd6, 1'b0);
    add_req(1'b1, 32'd9, 32'd9, 1'b0);
    wait_idle();
    check_grants("simul", 2, 4'b0010);
  endtask

  task automatic test_back_to_back();
    grant_log.delete();
    add_req(1'b0, 32'd2, 32'd3, 1'b0);
    add_req(1'b1, 32'd6, 32'd7, 1'b0);
    add_req(1'b0, 32'd4, 32'd5, 1'b0);
    add_req(1'b1, 32'd8, 32'd9, 1'b0);
    wait_idle();
    check_grants("b2b", 4, 4'b1010);
  endtask

  task automatic test_slow_consumer();
    int a0;
    grant_log.delete();
    ack_delay = 10;
    add_req(1'b0, 32'd5, 32'd5, 1'b0);
    wait_grant(0);
    a0 = ack_count[0];
    add_req(1'b1, 32'd3, 32'd4, 1'b0);
    wait_grant(1);
    checks++;
    if (ack_count[0] != a0 + 1) begin
      errors++;
      $display("FAIL slow_grant_early: requester 1 granted with %0d acks from 0, want %0d", ack_count[0] - a0, 1);
    end
    wait_idle();
    ack_delay = 0;
    check_grants("slow", 2, 4'b0010);
  endtask

  task automatic test_timeout();
    int n = 0;
    stall = 1'b1;
    add_req(1'b0, 32'd11, 32'd2, 1'b1);
    wait_grant(0);
    while (mul_valid_data === 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n != TO || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_expiry: %0d ISSUE cycles timeout_err=%b, want %0d and 1", n, timeout_err, TO);
    end
    wait_idle();
    stall = 1'b0;
    add_req(1'b1, 32'd6, 32'd7, 1'b0);
    wait_idle();
    checks++;
    if (timeout_err !== 1'b1 || rsp_producto !== 64'd42) begin
      errors++;
      $display("FAIL timeout_sticky: timeout_err=%b producto=%0d, want 1 and 42", timeout_err, rsp_producto);
    end
  endtask

  task automatic test_reset_mid();
    grant_log.delete();
    add_req(1'b0, 32'd123456, 32'd789, 1'b0);
    wait_grant(0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({req_grant, rsp_valid, rsp_producto, mul_a, mul_b, mul_valid_data, mul_ack, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: grant=%b rsp_valid=%b prod=%0d a=%0d b=%0d vd=%b ack=%b busy=%b to=%b, want all 0",
               req_grant, rsp_valid, rsp_producto, mul_a, mul_b, mul_valid_data, mul_ack, busy, timeout_err);
    end
    sb.delete();
    grant_log.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (grant_log.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_drop: %0d grants busy=%b after reset, want 0 and 0", grant_log.size(), busy);
    end
    add_req(1'b0, 32'd123456, 32'd789, 1'b0);
    wait_idle();
    check_grants("midreset_retry", 1, 4'b0000);
    checks++;
    if (rsp_producto !== 64'd97406784) begin
      errors++;
      $display("FAIL midreset_product: got %0d, want 97406784", rsp_producto);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_slow_consumer();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
